// File: rtl/route_distributor_seq.sv
// Route distributor: allocates requesting channels to enabled capacitor slots,
// holds each slot for HOLD_CYC cycles, then releases it with a done pulse.
module route_distributor_seq #(
    parameter int CHANNEL_NUM   = 8,
    parameter int CAPACITOR_NUM = 4,
    parameter int HOLD_CYC      = 4,
    localparam int CH_W         = $clog2(CHANNEL_NUM)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [CHANNEL_NUM-1:0]        din,
    input  logic [CAPACITOR_NUM-1:0]      sw,
    output logic [CAPACITOR_NUM-1:0]      dout,
    output logic [CAPACITOR_NUM*CH_W-1:0] slot_ch,
    output logic [CHANNEL_NUM-1:0]        gnt,
    output logic [CHANNEL_NUM-1:0]        done
);

    // state | meaning
    // FREE  | slot idle, may take a channel when its sw bit is set
    // BUSY  | slot holding slot_ch for the remaining cnt+1 cycles
    localparam logic [0:0] ST_FREE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int CNT_W = $clog2(HOLD_CYC + 1);

    logic [CAPACITOR_NUM-1:0]            state_q, state_d;
    logic [CAPACITOR_NUM-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [CAPACITOR_NUM*CH_W-1:0]       slot_ch_q, slot_ch_d;
    logic [CHANNEL_NUM-1:0]              gnt_q, gnt_d;
    logic [CHANNEL_NUM-1:0]              done_q, done_d;
    logic [CH_W-1:0]                     rr_ptr_q, rr_ptr_d;

    always_comb begin
        logic [CHANNEL_NUM-1:0] cand;
        logic                   found;
        logic                   alloc_any;
        logic [CH_W-1:0]        cur;
        logic [CH_W-1:0]        chi;
        int                     ch;
        int                     last_off;

        state_d   = state_q;
        cnt_d     = cnt_q;
        slot_ch_d = slot_ch_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        rr_ptr_d  = rr_ptr_q;
        cand      = din & ~gnt_q;
        alloc_any = 1'b0;
        last_off  = 0;
        found     = 1'b0;
        cur       = '0;
        chi       = '0;
        ch        = 0;

        for (int k = 0; k < CAPACITOR_NUM; k++) begin
            if (state_q[k] == ST_BUSY) begin
                cur = slot_ch_q[k*CH_W +: CH_W];
                if (!sw[k]) begin
                    // abort: release silently, no completion reported
                    state_d[k] = ST_FREE;
                    gnt_d[cur] = 1'b0;
                end else if (cnt_q[k] == '0) begin
                    state_d[k]  = ST_FREE;
                    gnt_d[cur]  = 1'b0;
                    done_d[cur] = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] - CNT_W'(1);
                end
            end else if (sw[k]) begin
                found = 1'b0;
                for (int i = 0; i < CHANNEL_NUM; i++) begin
                    ch = int'(rr_ptr_q) + i;
                    if (ch >= CHANNEL_NUM) ch = ch - CHANNEL_NUM;
                    chi = CH_W'(ch);
                    if (!found && cand[chi]) begin
                        found                      = 1'b1;
                        cand[chi]                  = 1'b0;
                        state_d[k]                 = ST_BUSY;
                        cnt_d[k]                   = CNT_W'(HOLD_CYC - 1);
                        slot_ch_d[k*CH_W +: CH_W]  = chi;
                        gnt_d[chi]                 = 1'b1;
                        alloc_any                  = 1'b1;
                        if (i > last_off) last_off = i;
                    end
                end
            end
        end

        // next search starts just past the furthest channel served this round
        if (alloc_any) begin
            ch = int'(rr_ptr_q) + last_off + 1;
            if (ch >= CHANNEL_NUM) ch = ch - CHANNEL_NUM;
            rr_ptr_d = CH_W'(ch);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= {CAPACITOR_NUM{ST_FREE}};
            cnt_q     <= '0;
            slot_ch_q <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            slot_ch_q <= slot_ch_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign dout    = state_q;
    assign slot_ch = slot_ch_q;
    assign gnt     = gnt_q;
    assign done    = done_q;

endmodule

// File: tb/tb_route_distributor_seq.sv
// Directed bench for route_distributor_seq (8 channels, 4 slots, hold 4).
module tb_route_distributor_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  din = '0;
    logic [3:0]  sw = '0;
    logic [3:0]  dout;
    logic [11:0] slot_ch;
    logic [7:0]  gnt;
    logic [7:0]  done;

    int nvec = 0;
    int nerr = 0;

    // one row: inputs applied before an edge, outputs expected after it
    typedef struct packed {
        logic [7:0]  din;
        logic [3:0]  sw;
        logic [3:0]  dout;
        logic [7:0]  gnt;
        logic [7:0]  done;
        logic [11:0] sc;
    } row_t;

    route_distributor_seq #(
        .CHANNEL_NUM(8),
        .CAPACITOR_NUM(4),
        .HOLD_CYC(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .din(din),
        .sw(sw),
        .dout(dout),
        .slot_ch(slot_ch),
        .gnt(gnt),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        din = '0;
        sw  = '0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        nvec++;
        if ({dout, gnt, done, slot_ch} !== 32'h0) begin
            nerr++;
            $display("FAIL reset_async: dout=%h gnt=%h done=%h slot_ch=%h, expected all 0",
                     dout, gnt, done, slot_ch);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        sw = 4'hF;
        @(posedge clk);
        #1;
        nvec++;
        if ({dout, gnt, done, slot_ch} !== 32'h0) begin
            nerr++;
            $display("FAIL reset_idle: dout=%h gnt=%h done=%h slot_ch=%h, expected all 0",
                     dout, gnt, done, slot_ch);
        end
    endtask

    task automatic test_basic();
        row_t t [6];
        t[0] = '{8'h05, 4'hF, 4'h3, 8'h05, 8'h00, 12'h010};
        t[1] = '{8'h00, 4'hF, 4'h3, 8'h05, 8'h00, 12'h010};
        t[2] = '{8'h00, 4'hF, 4'h3, 8'h05, 8'h00, 12'h010};
        t[3] = '{8'h00, 4'hF, 4'h3, 8'h05, 8'h00, 12'h010};
        t[4] = '{8'h00, 4'hF, 4'h0, 8'h00, 8'h05, 12'h010};
        t[5] = '{8'hFF, 4'h1, 4'h1, 8'h08, 8'h00, 12'h013};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            din = t[i].din;
            sw  = t[i].sw;
            @(posedge clk);
            #1;
            nvec++;
            if ({dout, gnt, done, slot_ch} !== {t[i].dout, t[i].gnt, t[i].done, t[i].sc}) begin
                nerr++;
                $display("FAIL basic row %0d: dout=%h gnt=%h done=%h slot_ch=%h, expected %h %h %h %h",
                         i, dout, gnt, done, slot_ch, t[i].dout, t[i].gnt, t[i].done, t[i].sc);
            end
        end
    endtask

    task automatic test_round_robin();
        row_t t [11];
        t[0]  = '{8'hFF, 4'hF, 4'hF, 8'h0F, 8'h00, 12'h688};
        t[1]  = '{8'hFF, 4'hF, 4'hF, 8'h0F, 8'h00, 12'h688};
        t[2]  = '{8'hFF, 4'hF, 4'hF, 8'h0F, 8'h00, 12'h688};
        t[3]  = '{8'hFF, 4'hF, 4'hF, 8'h0F, 8'h00, 12'h688};
        t[4]  = '{8'hFF, 4'hF, 4'h0, 8'h00, 8'h0F, 12'h688};
        t[5]  = '{8'hFF, 4'hF, 4'hF, 8'hF0, 8'h00, 12'hFAC};
        t[6]  = '{8'hFF, 4'hF, 4'hF, 8'hF0, 8'h00, 12'hFAC};
        t[7]  = '{8'hFF, 4'hF, 4'hF, 8'hF0, 8'h00, 12'hFAC};
        t[8]  = '{8'hFF, 4'hF, 4'hF, 8'hF0, 8'h00, 12'hFAC};
        t[9]  = '{8'hFF, 4'hF, 4'h0, 8'h00, 8'hF0, 12'hFAC};
        t[10] = '{8'hFF, 4'hF, 4'hF, 8'h0F, 8'h00, 12'h688};
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            din = t[i].din;
            sw  = t[i].sw;
            @(posedge clk);
            #1;
            nvec++;
            if ({dout, gnt, done, slot_ch} !== {t[i].dout, t[i].gnt, t[i].done, t[i].sc}) begin
                nerr++;
                $display("FAIL round_robin row %0d: dout=%h gnt=%h done=%h slot_ch=%h, expected %h %h %h %h",
                         i, dout, gnt, done, slot_ch, t[i].dout, t[i].gnt, t[i].done, t[i].sc);
            end
        end
    endtask

    task automatic test_slot_skip();
        row_t t [6];
        t[0] = '{8'h03, 4'hA, 4'hA, 8'h03, 8'h00, 12'h200};
        t[1] = '{8'h03, 4'hA, 4'hA, 8'h03, 8'h00, 12'h200};
        t[2] = '{8'h03, 4'hA, 4'hA, 8'h03, 8'h00, 12'h200};
        t[3] = '{8'h03, 4'hA, 4'hA, 8'h03, 8'h00, 12'h200};
        t[4] = '{8'h03, 4'hA, 4'h0, 8'h00, 8'h03, 12'h200};
        t[5] = '{8'h03, 4'hA, 4'hA, 8'h03, 8'h00, 12'h200};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            din = t[i].din;
            sw  = t[i].sw;
            @(posedge clk);
            #1;
            nvec++;
            if ({dout, gnt, done, slot_ch} !== {t[i].dout, t[i].gnt, t[i].done, t[i].sc}) begin
                nerr++;
                $display("FAIL slot_skip row %0d: dout=%h gnt=%h done=%h slot_ch=%h, expected %h %h %h %h",
                         i, dout, gnt, done, slot_ch, t[i].dout, t[i].gnt, t[i].done, t[i].sc);
            end
        end
    endtask

    task automatic test_abort();
        row_t t [6];
        t[0] = '{8'h01, 4'hF, 4'h1, 8'h01, 8'h00, 12'h000};
        t[1] = '{8'h00, 4'hF, 4'h1, 8'h01, 8'h00, 12'h000};
        t[2] = '{8'h00, 4'hE, 4'h0, 8'h00, 8'h00, 12'h000};
        t[3] = '{8'h00, 4'hE, 4'h0, 8'h00, 8'h00, 12'h000};
        t[4] = '{8'h00, 4'hE, 4'h0, 8'h00, 8'h00, 12'h000};
        t[5] = '{8'h00, 4'hE, 4'h0, 8'h00, 8'h00, 12'h000};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            din = t[i].din;
            sw  = t[i].sw;
            @(posedge clk);
            #1;
            nvec++;
            if ({dout, gnt, done, slot_ch} !== {t[i].dout, t[i].gnt, t[i].done, t[i].sc}) begin
                nerr++;
                $display("FAIL abort row %0d: dout=%h gnt=%h done=%h slot_ch=%h, expected %h %h %h %h",
                         i, dout, gnt, done, slot_ch, t[i].dout, t[i].gnt, t[i].done, t[i].sc);
            end
        end
    endtask

    task automatic test_wrap();
        row_t t [11];
        t[0]  = '{8'h20, 4'h1, 4'h1, 8'h20, 8'h00, 12'h005};
        t[1]  = '{8'h00, 4'h1, 4'h1, 8'h20, 8'h00, 12'h005};
        t[2]  = '{8'h00, 4'h1, 4'h1, 8'h20, 8'h00, 12'h005};
        t[3]  = '{8'h00, 4'h1, 4'h1, 8'h20, 8'h00, 12'h005};
        t[4]  = '{8'h00, 4'h1, 4'h0, 8'h00, 8'h20, 12'h005};
        t[5]  = '{8'hC1, 4'h3, 4'h3, 8'hC0, 8'h00, 12'h03E};
        t[6]  = '{8'hC1, 4'h3, 4'h3, 8'hC0, 8'h00, 12'h03E};
        t[7]  = '{8'hC1, 4'h3, 4'h3, 8'hC0, 8'h00, 12'h03E};
        t[8]  = '{8'hC1, 4'h3, 4'h3, 8'hC0, 8'h00, 12'h03E};
        t[9]  = '{8'hC1, 4'h3, 4'h0, 8'h00, 8'hC0, 12'h03E};
        t[10] = '{8'hC1, 4'h3, 4'h3, 8'h41, 8'h00, 12'h030};
        apply_reset();
        for (int i = 0; i < 11; i++) begin
            din = t[i].din;
            sw  = t[i].sw;
            @(posedge clk);
            #1;
            nvec++;
            if ({dout, gnt, done, slot_ch} !== {t[i].dout, t[i].gnt, t[i].done, t[i].sc}) begin
                nerr++;
                $display("FAIL wrap row %0d: dout=%h gnt=%h done=%h slot_ch=%h, expected %h %h %h %h",
                         i, dout, gnt, done, slot_ch, t[i].dout, t[i].gnt, t[i].done, t[i].sc);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        apply_reset();
        din = 8'h03;
        sw  = 4'hF;
        repeat (2) begin
            @(posedge clk);
            #1;
            nvec++;
            if ({dout, gnt, done, slot_ch} !== {4'h3, 8'h03, 8'h00, 12'h008}) begin
                nerr++;
                $display("FAIL mid_hold_busy: dout=%h gnt=%h done=%h slot_ch=%h, expected 3 03 00 008",
                         dout, gnt, done, slot_ch);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        nvec++;
        if ({dout, gnt, done, slot_ch} !== 32'h0) begin
            nerr++;
            $display("FAIL mid_hold_async_clear: dout=%h gnt=%h done=%h slot_ch=%h, expected all 0",
                     dout, gnt, done, slot_ch);
        end
        #2 rst_n = 1'b1;
        din = 8'h01;
        @(posedge clk);
        #1;
        nvec++;
        if ({dout, gnt, done, slot_ch} !== {4'h1, 8'h01, 8'h00, 12'h000}) begin
            nerr++;
            $display("FAIL post_reset_grant: dout=%h gnt=%h done=%h slot_ch=%h, expected 1 01 00 000",
                     dout, gnt, done, slot_ch);
        end
        din = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        nvec++;
        if ({dout, gnt, done} !== {4'h1, 8'h01, 8'h00}) begin
            nerr++;
            $display("FAIL post_reset_hold: dout=%h gnt=%h done=%h, expected 1 01 00", dout, gnt, done);
        end
        @(posedge clk);
        #1;
        nvec++;
        if ({dout, gnt, done} !== {4'h0, 8'h00, 8'h01}) begin
            nerr++;
            $display("FAIL post_reset_done: dout=%h gnt=%h done=%h, expected 0 00 01", dout, gnt, done);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_slot_skip();
        test_abort();
        test_wrap();
        test_reset_mid_hold();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/route_distributor_seq.md
Name: route_distributor_seq

Overview:
- Sequential, parametrised route distributor that allocates requesting channels to enabled capacitor slots.
- Holds each allocation for a programmable number of cycles, then releases the slot and signals completion to the channel.
- Uses a round-robin start pointer so every channel is eventually served when requests exceed slots.
- Sits between the channel request front-end and the capacitor switch array.

Parameters:
- CHANNEL_NUM, 8, number of requesting channels (>=2; need not be a power of 2).
- CAPACITOR_NUM, 4, number of capacitor slots (>=1).
- HOLD_CYC, 4, cycles a slot stays busy per allocation (>=1).
- CH_W, $clog2(CHANNEL_NUM), localparam, width of one channel index.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  CHANNEL_NUM  per-channel request, level-sensitive.
- sw  input  CAPACITOR_NUM  per-slot enable; 0 = slot unavailable / abort.
- dout  output  CAPACITOR_NUM  slot busy flags.
- slot_ch  output  CAPACITOR_NUM*CH_W  channel index held by each slot; slot k occupies bits [k*CH_W +: CH_W].
- gnt  output  CHANNEL_NUM  channel currently being served (level).
- done  output  CHANNEL_NUM  one-cycle pulse on normal completion of service.

Behaviour:
- Reset (rst_n=0, asynchronous): dout, slot_ch, gnt, done, the round-robin pointer rr_ptr and all slot counters go to 0. All slots enter FREE.
- Each slot has an FSM with two states, FREE and BUSY, plus a counter cnt of width $clog2(HOLD_CYC+1).

Allocation (combinational from registered state, committed at the next edge):
- cand = din & ~gnt.
- Visit slots in ascending order, 0 to CAPACITOR_NUM-1.
- Each slot that is FREE with sw[k]=1 takes the first channel in cand. The search starts at rr_ptr and goes upward, wrapping modulo CHANNEL_NUM.
- The chosen channel is removed from cand before the next slot is visited. No channel is ever given two slots.

On the allocation edge:
- Slot goes to BUSY; dout[k]=1; slot_ch[k]=channel index; gnt[ch]=1; cnt=HOLD_CYC-1.
- Latency: din rising to gnt is 1 cycle.
- If any allocation occurred, rr_ptr <= (highest-order channel allocated in search order)+1, modulo CHANNEL_NUM. Otherwise rr_ptr holds.

BUSY:
- cnt decrements by 1 each cycle.
- On the edge where cnt==0: slot goes FREE; dout[k]=0; gnt[ch]=0; done[ch]=1 for exactly one cycle. dout therefore stays high for exactly HOLD_CYC cycles.
- slot_ch keeps its last value while the slot is FREE.
- din dropping during BUSY has no effect; service completes.

Abort:
- sw[k]=0 while the slot is BUSY: the slot goes FREE on the next edge and gnt clears.
- No done pulse is generated and rr_ptr is unaffected.

Re-allocation timing:
- A freed slot is allocatable one cycle after release, because allocation uses registered state.
- A released channel whose din is still high competes again on the cycle after done.

Boundary cases:
- More candidates than free, enabled slots: the excess channels wait; no loss, no error.
- More slots than candidates: the remaining slots stay FREE.
- sw[k]=0 while FREE: the slot is skipped.
- Release and new allocation of different slots on the same edge are both performed.
- Reset mid-hold: all outputs clear immediately. No done pulse is generated.

Test Plan (CHANNEL_NUM=8, CAPACITOR_NUM=4, HOLD_CYC=4):
1. After reset, din=8'b0000_0101, sw=4'hF -> next cycle: dout=4'b0011, slot0=ch0, slot1=ch2, gnt=8'h05. After 4 busy cycles: done=8'h05 for 1 cycle, dout=0, rr_ptr=3.
2. din=8'hFF held, sw=4'hF -> first grant round: ch0–3, rr_ptr=4. After release plus one cycle, second round: ch4–7 in slots 0–3, rr_ptr=0.
3. din=8'h03, sw=4'b1010 -> dout=4'b1010, slot1=ch0, slot3=ch1; slots 0 and 2 stay FREE.
4. ch0 granted in slot0; drop sw[0] on busy cycle 2 -> next edge: dout[0]=0, gnt[0]=0. done stays 0 throughout.
5. Force rr_ptr=6 (via a prior round), din=8'b1100_0001, sw=4'b0011 -> slot0=ch6, slot1=ch7, rr_ptr wraps to 0. ch0 waits and is granted after the next release.
6. Assert rst_n=0 mid-hold with 2 slots busy -> dout, gnt, done and slot_ch are 0 immediately, without waiting for a clock edge. After release with din=8'h01, ch0 is granted 1 cycle later in slot0.
